// File: rtl/call_return_ctrl_pkg.sv
// Shared constants and state encoding for the call/return sequencer.
// Used by the controller and anything that models the return-address stack.
package call_return_ctrl_pkg;

    localparam int DATA_W         = 32;
    localparam int RET_OFFSET     = 4;
    localparam int STACK_DEPTH    = 16;
    localparam int SETTLE_CYCLES  = 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CALL_PUSH = 2'd1;
    localparam logic [1:0] ST_RET_POP   = 2'd2;
    localparam logic [1:0] ST_SETTLE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_CALL_PUSH = ST_CALL_PUSH,
        S_RET_POP   = ST_RET_POP,
        S_SETTLE    = ST_SETTLE
    } state_t;

endpackage

// File: rtl/call_return_ctrl.sv
// Sequences CALL/RET against the return-address stack, waiting out the
// stack's lagging full/empty flags before accepting the next operation.
module call_return_ctrl
    import call_return_ctrl_pkg::*;
#(
    parameter int DATA_W_P        = DATA_W,
    parameter int RET_OFFSET_P    = RET_OFFSET,
    parameter int SETTLE_CYCLES_P = SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_call,
    input  logic                start_ret,
    input  logic [DATA_W_P-1:0] pc_current,
    input  logic [DATA_W_P-1:0] call_target,
    output logic                busy,
    output logic                done,
    output logic                pc_load,
    output logic [DATA_W_P-1:0] next_pc,
    output logic                fault_overflow,
    output logic                fault_underflow,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_W_P-1:0] stk_din,
    input  logic [DATA_W_P-1:0] stk_dout,
    input  logic                stk_empty,
    input  logic                stk_full
);

    localparam logic [1:0] W_SETTLE_LOAD = 2'(SETTLE_CYCLES_P - 1);
    localparam logic [DATA_W_P-1:0] W_OFFSET = DATA_W_P'(RET_OFFSET_P);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_pc_load;
    logic [DATA_W_P-1:0] r_next_pc;
    logic                r_fov;
    logic                r_fun;
    logic                r_push;
    logic                r_pop;
    logic [DATA_W_P-1:0] r_din;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pc_load <= 1'b0;
            r_next_pc <= '0;
            r_fov     <= 1'b0;
            r_fun     <= 1'b0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_din     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_pc_load <= 1'b0;
            r_fov     <= 1'b0;
            r_fun     <= 1'b0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // CALL has priority; a simultaneous RET is dropped
                    if (start_call) begin
                        if (stk_full) begin
                            r_fov  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= S_CALL_PUSH;
                            r_busy    <= 1'b1;
                            r_push    <= 1'b1;
                            r_din     <= pc_current + W_OFFSET;
                            r_pc_load <= 1'b1;
                            r_next_pc <= call_target;
                        end
                    end else if (start_ret) begin
                        if (stk_empty) begin
                            r_fun  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= S_RET_POP;
                            r_busy    <= 1'b1;
                            r_pop     <= 1'b1;
                            r_pc_load <= 1'b1;
                            r_next_pc <= stk_dout;
                        end
                    end
                end
                S_CALL_PUSH, S_RET_POP: begin
                    r_state <= S_SETTLE;
                    r_cnt   <= W_SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pc_load         = r_pc_load;
    assign next_pc         = r_next_pc;
    assign fault_overflow  = r_fov;
    assign fault_underflow = r_fun;
    assign stk_push        = r_push;
    assign stk_pop         = r_pop;
    assign stk_din         = r_din;

endmodule
